// File: rtl/psum_accum_ctrl_pkg.sv
// Shared widths, FSM encoding and sign-extension helper for the partial-sum accumulation controller.
package psum_accum_ctrl_pkg;

    localparam int W_IN   = 22;
    localparam int W_PSUM = 32;
    localparam int DEPTH  = 64;
    localparam int W_CNT  = 16;
    localparam int W_PIX  = $clog2(DEPTH + 1);
    localparam int W_IDX  = $clog2(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic [W_PSUM-1:0] sext_in(input logic [W_IN-1:0] v);
        return {{(W_PSUM - W_IN){v[W_IN-1]}}, v};
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_if.sv
// Config, tree-result and drain-stream bundle; the controller sits on the slave side.
interface psum_accum_ctrl_if;
    import psum_accum_ctrl_pkg::*;

    logic              start;
    logic [W_PIX-1:0]  cfg_num_pix;
    logic [W_CNT-1:0]  cfg_num_cgrp;
    logic              issue_en;
    logic              tree_vld;
    logic [W_IN-1:0]   tree_acc;
    logic              out_vld;
    logic              out_rdy;
    logic [W_PSUM-1:0] out_data;
    logic [W_IDX-1:0]  out_idx;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, cfg_num_pix, cfg_num_cgrp, tree_vld, tree_acc, out_rdy,
        input  issue_en, out_vld, out_data, out_idx, busy, done, err
    );

    modport slave (
        input  start, cfg_num_pix, cfg_num_cgrp, tree_vld, tree_acc, out_rdy,
        output issue_en, out_vld, out_data, out_idx, busy, done, err
    );

endinterface

// File: rtl/psum_buf.sv
// Per-pixel partial-sum register array: one write port, two combinational read ports.
// No reset on the array; the first channel-group pass overwrites every live entry.
module psum_buf
    import psum_accum_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [W_IDX-1:0]  wr_addr,
    input  logic [W_PSUM-1:0] wr_data,
    input  logic [W_IDX-1:0]  acc_addr,
    output logic [W_PSUM-1:0] acc_data,
    input  logic [W_IDX-1:0]  drn_addr,
    output logic [W_PSUM-1:0] drn_data
);

    logic [W_PSUM-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign acc_data = mem[acc_addr];
    assign drn_data = mem[drn_addr];

endmodule

// File: rtl/psum_accum_ctrl.sv
// Accumulates adder-tree results per pixel over channel-group passes, then drains finished sums.
// Read-modify-write completes in the sampling cycle; drain holds data/index while out_rdy is low.
module psum_accum_ctrl
    import psum_accum_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    psum_accum_ctrl_if.slave bus
);

    state_t            state;
    state_t            state_nxt;
    logic [W_PIX-1:0]  num_pix;
    logic [W_CNT-1:0]  num_cgrp;
    logic [W_IDX-1:0]  pix_cnt;
    logic [W_CNT-1:0]  grp_cnt;
    logic [W_IDX-1:0]  drain_idx;
    logic              err_q;

    logic              start_ok;
    logic              zero_cfg;
    logic              sample;
    logic              pix_last;
    logic              grp_last;
    logic              drn_last;
    logic              beat;
    logic [W_PSUM-1:0] acc_data;
    logic [W_PSUM-1:0] drn_data;
    logic [W_PSUM-1:0] wr_data;

    assign start_ok = bus.start && (state == ST_IDLE);
    assign zero_cfg = (bus.cfg_num_pix == '0) || (bus.cfg_num_cgrp == '0);
    assign sample   = bus.tree_vld && (state == ST_ACCUM);
    assign pix_last = ({1'b0, pix_cnt} == (num_pix - W_PIX'(1)));
    assign grp_last = (grp_cnt == (num_cgrp - W_CNT'(1)));
    assign drn_last = ({1'b0, drain_idx} == (num_pix - W_PIX'(1)));
    assign beat     = (state == ST_DRAIN) && bus.out_rdy;

    // First pass overwrites so stale contents never leak into a new tile.
    assign wr_data = ((grp_cnt == '0) ? '0 : acc_data) + sext_in(bus.tree_acc);

    psum_buf u_buf (
        .clk      (clk),
        .wr_en    (sample),
        .wr_addr  (pix_cnt),
        .wr_data  (wr_data),
        .acc_addr (pix_cnt),
        .acc_data (acc_data),
        .drn_addr (drain_idx),
        .drn_data (drn_data)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start) state_nxt = zero_cfg ? ST_DONE : ST_ACCUM;
            ST_ACCUM: if (sample && pix_last && grp_last) state_nxt = ST_DRAIN;
            ST_DRAIN: if (beat && drn_last) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_pix   <= '0;
            num_cgrp  <= '0;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
            drain_idx <= '0;
        end else if (start_ok) begin
            num_pix   <= bus.cfg_num_pix;
            num_cgrp  <= bus.cfg_num_cgrp;
            pix_cnt   <= '0;
            grp_cnt   <= '0;
            drain_idx <= '0;
        end else if (sample) begin
            if (pix_last) begin
                pix_cnt   <= '0;
                grp_cnt   <= grp_cnt + W_CNT'(1);
                drain_idx <= '0;
            end else begin
                pix_cnt <= pix_cnt + W_IDX'(1);
            end
        end else if (beat) begin
            drain_idx <= drain_idx + W_IDX'(1);
        end
    end

    // A stray sample in the same cycle as a start still flags the error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.tree_vld && (state != ST_ACCUM)) begin
            err_q <= 1'b1;
        end else if (start_ok) begin
            err_q <= 1'b0;
        end
    end

    assign bus.issue_en = (state == ST_ACCUM);
    assign bus.out_vld  = (state == ST_DRAIN);
    assign bus.out_data = (state == ST_DRAIN) ? drn_data : '0;
    assign bus.out_idx  = (state == ST_DRAIN) ? drain_idx : '0;
    assign bus.busy     = (state != ST_IDLE);
    assign bus.done     = (state == ST_DONE);
    assign bus.err      = err_q;

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Scoreboard bench: expected sums queued as samples are driven, compared on each accepted drain beat.
module tb_psum_accum_ctrl;
    import psum_accum_ctrl_pkg::*;

    typedef struct packed {
        logic [W_IDX-1:0]  idx;
        logic [W_PSUM-1:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    psum_accum_ctrl_if bus();

    psum_accum_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    beat_t             sb[$];
    beat_t             exp_beat;
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                last_beat_cyc = 0;
    int                done_cyc = 0;
    int                done_cnt = 0;
    bit                done_seen = 0;
    bit                stalled = 0;
    logic [W_PSUM-1:0] st_data;
    logic [W_IDX-1:0]  st_idx;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.done) begin
            done_seen = 1;
            done_cyc  = cyc;
            done_cnt++;
        end
        if (bus.out_vld) begin
            if (stalled) begin
                check("stall_idx", 32'(bus.out_idx), 32'(st_idx));
                check("stall_data", bus.out_data, st_data);
            end
            if (bus.out_rdy) begin
                if (sb.size() == 0) begin
                    check("extra_beat", 32'(1), 32'(0));
                end else begin
                    exp_beat = sb.pop_front();
                    check("beat_idx", 32'(bus.out_idx), 32'(exp_beat.idx));
                    check("beat_data", bus.out_data, exp_beat.data);
                end
                last_beat_cyc = cyc;
                stalled = 0;
            end else begin
                stalled = 1;
                st_data = bus.out_data;
                st_idx  = bus.out_idx;
            end
        end else begin
            stalled = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_tile(input int np, input int ng);
        bus.start        = 1'b1;
        bus.cfg_num_pix  = W_PIX'(np);
        bus.cfg_num_cgrp = W_CNT'(ng);
        tick();
        bus.start        = 1'b0;
        bus.cfg_num_pix  = W_PIX'($urandom_range(1, 64));
        bus.cfg_num_cgrp = W_CNT'($urandom_range(1, 9));
    endtask

    // mode 0: all +5; 1: pass g gives g+1; 2: +max then -min; 3: random.
    task automatic run_tile(input int np, input int ng, input int mode, input bit toggle, input bit poke_start);
        int              sums[DEPTH];
        logic [W_IN-1:0] v;
        int              n;
        done_seen = 0;
        done_cnt  = 0;
        start_tile(np, ng);
        check("busy_start", 32'(bus.busy), 32'(1));
        check("issue_start", 32'(bus.issue_en), 32'(1));
        check("err_after_start", 32'(bus.err), 32'(0));
        for (int g = 0; g < ng; g++) begin
            for (int p = 0; p < np; p++) begin
                case (mode)
                    0:       v = W_IN'(5);
                    1:       v = W_IN'(g + 1);
                    2:       v = (g == 0) ? 22'h1FFFFF : 22'h200000;
                    default: v = W_IN'($urandom);
                endcase
                sums[p] = ((g == 0) ? 0 : sums[p]) + int'($signed(v));
                bus.tree_vld = 1'b1;
                bus.tree_acc = v;
                tick();
            end
        end
        bus.tree_vld = 1'b0;
        for (int p = 0; p < np; p++) begin
            sb.push_back('{idx: W_IDX'(p), data: W_PSUM'(sums[p])});
        end
        check("issue_after_last", 32'(bus.issue_en), 32'(0));
        check("vld_after_last", 32'(bus.out_vld), 32'(1));
        bus.out_rdy = 1'b1;
        n = 0;
        while (!done_seen && n < 400) begin
            if (toggle) bus.out_rdy = ~bus.out_rdy;
            bus.start = poke_start && (n == 2);
            if (bus.start) bus.cfg_num_pix = '0;
            tick();
            n++;
        end
        bus.start   = 1'b0;
        bus.out_rdy = 1'b1;
        if (!done_seen) begin
            check("done_timeout", 32'(0), 32'(1));
        end else begin
            check("done_lat", 32'(done_cyc - last_beat_cyc), 32'(1));
            check("busy_end", 32'(bus.busy), 32'(0));
            check("done_cnt", 32'(done_cnt), 32'(1));
        end
        check("sb_empty", 32'(sb.size()), 32'(0));
        sb.delete();
    endtask

    initial begin
        bus.start        = 1'b0;
        bus.cfg_num_pix  = '0;
        bus.cfg_num_cgrp = '0;
        bus.tree_vld     = 1'b0;
        bus.tree_acc     = '0;
        bus.out_rdy      = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("rst_issue_en", 32'(bus.issue_en), 32'(0));
        check("rst_out_vld", 32'(bus.out_vld), 32'(0));
        check("rst_out_data", bus.out_data, 32'(0));
        check("rst_out_idx", 32'(bus.out_idx), 32'(0));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_done", 32'(bus.done), 32'(0));
        check("rst_err", 32'(bus.err), 32'(0));
        tick();
        tick();
        rst = 1'b0;
        tick();

        run_tile(4, 3, 0, 1'b0, 1'b0);
        run_tile(1, 8, 1, 1'b0, 1'b0);
        run_tile(2, 2, 2, 1'b0, 1'b0);
        run_tile(4, 2, 3, 1'b1, 1'b0);

        // Stray sample while idle, then a tile that clears err and ignores a start mid-drain.
        bus.tree_vld = 1'b1;
        bus.tree_acc = W_IN'(123);
        tick();
        bus.tree_vld = 1'b0;
        check("err_set", 32'(bus.err), 32'(1));
        tick();
        check("err_sticky", 32'(bus.err), 32'(1));
        run_tile(3, 2, 3, 1'b0, 1'b1);

        // Zero-size tile goes straight to done without a drain.
        start_tile(0, 3);
        check("zero_done", 32'(bus.done), 32'(1));
        check("zero_out_vld", 32'(bus.out_vld), 32'(0));
        tick();
        check("zero_done_clr", 32'(bus.done), 32'(0));
        check("zero_busy", 32'(bus.busy), 32'(0));

        // Abort mid-accumulation, then a fresh tile.
        start_tile(4, 2);
        for (int i = 0; i < 3; i++) begin
            bus.tree_vld = 1'b1;
            bus.tree_acc = W_IN'(7);
            tick();
        end
        bus.tree_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_issue_en", 32'(bus.issue_en), 32'(0));
        check("abort_busy", 32'(bus.busy), 32'(0));
        check("abort_out_vld", 32'(bus.out_vld), 32'(0));
        check("abort_done", 32'(bus.done), 32'(0));
        check("abort_err", 32'(bus.err), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        run_tile(4, 2, 3, 1'b0, 1'b0);
        run_tile(8, 3, 3, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
